// File: rtl/i_ref_dac_if.sv
// rtl/i_ref_dac_if.sv - serial current-reference DAC writer with LDAC strobe.
// Optional step-size clamping when DAC_SLEW_LIMIT_EN is defined.
module i_ref_dac_if #(
   parameter int BUS_WIDTH = 10,
   parameter int CLK_DIV   = 4,
   parameter int MAX_STEP  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [BUS_WIDTH-1:0] i_ref_in,
   output logic                 dac_cs_n,
   output logic                 dac_sclk,
   output logic                 dac_sdi,
   output logic                 dac_ldac_n,
   output logic                 busy,
   output logic                 update_done,
   output logic [BUS_WIDTH-1:0] i_ref_applied
);

   localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BCW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(BUS_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_LDAC, S_DONE
   } state_t;

   state_t               state, state_nxt;
   logic [DW-1:0]        div_cnt, div_nxt;
   logic [BCW-1:0]       bit_cnt, bit_nxt;
   logic                 phase, phase_nxt;
   logic [BUS_WIDTH-1:0] shreg, shreg_nxt;
   logic [BUS_WIDTH-1:0] target_q, target_nxt;
   logic [BUS_WIDTH-1:0] applied_nxt;
   logic [BUS_WIDTH-1:0] next_target;
   logic                 div_end;

   logic cs_n_d, sclk_d, sdi_d, ldac_n_d, busy_d, done_d;

`ifdef DAC_SLEW_LIMIT_EN
   localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(MAX_STEP);
   logic signed [BUS_WIDTH:0] diff;

   // Clamp only fires when |diff| > MAX_STEP, so the stepped value cannot pass i_ref_in or wrap.
   always_comb begin
      diff = $signed({1'b0, i_ref_in}) - $signed({1'b0, i_ref_applied});
      if (int'(diff) > MAX_STEP)
         next_target = i_ref_applied + STEP;
      else if (int'(diff) < -MAX_STEP)
         next_target = i_ref_applied - STEP;
      else
         next_target = i_ref_in;
   end
`else
   assign next_target = i_ref_in;
`endif

   assign div_end = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         phase         <= 1'b0;
         shreg         <= '0;
         target_q      <= '0;
         i_ref_applied <= '0;
      end else begin
         state         <= state_nxt;
         div_cnt       <= div_nxt;
         bit_cnt       <= bit_nxt;
         phase         <= phase_nxt;
         shreg         <= shreg_nxt;
         target_q      <= target_nxt;
         i_ref_applied <= applied_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      div_nxt     = div_cnt;
      bit_nxt     = bit_cnt;
      phase_nxt   = phase;
      shreg_nxt   = shreg;
      target_nxt  = target_q;
      applied_nxt = i_ref_applied;
      case (state)
         S_IDLE: begin
            if (enable && (i_ref_in != i_ref_applied)) begin
               state_nxt  = S_CS_SETUP;
               div_nxt    = '0;
               target_nxt = next_target;
               shreg_nxt  = next_target;
            end
         end
         S_CS_SETUP: begin
            if (div_end) begin
               state_nxt = S_SHIFT;
               div_nxt   = '0;
               bit_nxt   = '0;
               phase_nxt = 1'b0;
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
         end
         S_SHIFT: begin
            if (div_end) begin
               div_nxt = '0;
               if (!phase) begin
                  phase_nxt = 1'b1;
               end else if (bit_cnt == BIT_LAST) begin
                  state_nxt = S_CS_HOLD;
               end else begin
                  // Next bit is presented at the start of its low phase.
                  phase_nxt = 1'b0;
                  bit_nxt   = bit_cnt + BCW'(1);
                  shreg_nxt = shreg << 1;
               end
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
         end
         S_CS_HOLD: begin
            if (div_end) begin
               state_nxt = S_LDAC;
               div_nxt   = '0;
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
         end
         S_LDAC: begin
            if (div_end) begin
               state_nxt   = S_DONE;
               div_nxt     = '0;
               applied_nxt = target_q;
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      cs_n_d   = 1'b1;
      sclk_d   = 1'b0;
      sdi_d    = 1'b0;
      ldac_n_d = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_nxt)
         S_CS_SETUP: begin
            cs_n_d = 1'b0;
            sdi_d  = shreg_nxt[BUS_WIDTH-1];
            busy_d = 1'b1;
         end
         S_SHIFT: begin
            cs_n_d = 1'b0;
            sclk_d = phase_nxt;
            sdi_d  = shreg_nxt[BUS_WIDTH-1];
            busy_d = 1'b1;
         end
         S_CS_HOLD: begin
            cs_n_d = 1'b0;
            sdi_d  = shreg_nxt[BUS_WIDTH-1];
            busy_d = 1'b1;
         end
         S_LDAC: begin
            ldac_n_d = 1'b0;
            busy_d   = 1'b1;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dac_cs_n    <= 1'b1;
         dac_sclk    <= 1'b0;
         dac_sdi     <= 1'b0;
         dac_ldac_n  <= 1'b1;
         busy        <= 1'b0;
         update_done <= 1'b0;
      end else begin
         dac_cs_n    <= cs_n_d;
         dac_sclk    <= sclk_d;
         dac_sdi     <= sdi_d;
         dac_ldac_n  <= ldac_n_d;
         busy        <= busy_d;
         update_done <= done_d;
      end
   end

endmodule

// File: tb/tb_i_ref_dac_if.sv
// tb/tb_i_ref_dac_if.sv - scoreboard bench for i_ref_dac_if.
module tb_i_ref_dac_if;

   localparam int BW = 10;
   localparam int CD = 4;
   localparam int MS = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [BW-1:0] i_ref_in;
   logic          dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, update_done;
   logic [BW-1:0] i_ref_applied;

   i_ref_dac_if #(.BUS_WIDTH(BW), .CLK_DIV(CD), .MAX_STEP(MS)) dut (
      .clk(clk), .rst(rst), .enable(enable), .i_ref_in(i_ref_in),
      .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
      .dac_ldac_n(dac_ldac_n), .busy(busy), .update_done(update_done),
      .i_ref_applied(i_ref_applied)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   int model = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int next_target(input int cur, input int want);
`ifdef DAC_SLEW_LIMIT_EN
      if (want > cur + MS) return cur + MS;
      if (want < cur - MS) return cur - MS;
`endif
      return want;
   endfunction

   // Monitor: reconstructs each SPI frame and scores it on update_done.
   int cyc = 0, c0 = 0, cap = 0, nbits = 0, ldac_len = 0, tim_err = 0;
   int frame_starts = 0, ldac_count = 0, done_count = 0;
   bit prev_cs = 1'b1, prev_sclk = 1'b0, prev_ldac = 1'b1, prev_done = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (prev_cs && !dac_cs_n) begin
         frame_starts++;
         c0 = cyc; cap = 0; nbits = 0; ldac_len = 0; tim_err = 0;
      end
      if (!prev_sclk && dac_sclk && !dac_cs_n) begin
         if (cyc != c0 + CD * (2 * nbits + 2)) tim_err++;
         cap = (cap << 1) | int'(dac_sdi);
         nbits++;
      end
      if (!dac_ldac_n) begin
         ldac_len++;
         if (prev_ldac) ldac_count++;
         if (!dac_cs_n) tim_err++;
      end
      if (update_done) begin
         done_count++;
         check("done_pulse_width", int'(prev_done), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
         end else begin
            int e;
            e = exp_q.pop_front();
            check("frame_word", cap, e);
            check("applied_at_done", int'(i_ref_applied), e);
            check("frame_bits", nbits, BW);
            check("ldac_len", ldac_len, CD);
            check("done_latency", cyc - c0, CD * (2 * BW + 3));
            check("sclk_timing_err", tim_err, 0);
            check("busy_at_done", int'(busy), 0);
         end
      end
      prev_cs   = dac_cs_n;
      prev_sclk = dac_sclk;
      prev_ldac = dac_ldac_n;
      prev_done = update_done;
   end

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (update_done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("done_timeout", 0, 1);
   endtask

   task automatic wait_busy();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("busy_timeout", 0, 1);
   endtask

   task automatic issue_one(input int v);
      int t;
      i_ref_in = BW'(v);
      t = next_target(model, v);
      exp_q.push_back(t);
      model = t;
   endtask

   task automatic drive_to(input int v);
      bit ok;
      i_ref_in = BW'(v);
      while (model != v) begin
         issue_one(v);
         wait_done(ok);
         if (!ok) begin
            exp_q.delete();
            return;
         end
      end
      repeat (3) @(negedge clk);
      check("settled_busy", int'(busy), 0);
      check("settled_applied", int'(i_ref_applied), v);
   endtask

   initial begin
      int fs, dc, lc, v;
      bit ok;
      rst = 1'b1; enable = 1'b0; i_ref_in = '0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", int'(dac_cs_n), 1);
      check("rst_sclk", int'(dac_sclk), 0);
      check("rst_sdi", int'(dac_sdi), 0);
      check("rst_ldac_n", int'(dac_ldac_n), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(update_done), 0);
      check("rst_applied", int'(i_ref_applied), 0);
      rst = 1'b0;

      enable = 1'b1;
      fs = frame_starts; dc = done_count;
      repeat (200) @(negedge clk);
      check("idle_no_frame", frame_starts - fs, 0);
      check("idle_no_done", done_count - dc, 0);

      drive_to(100);
      drive_to(60);
      drive_to('h155);

      drive_to(40);
      issue_one(50);
      wait_busy();
      repeat (30) @(negedge clk);
      i_ref_in = BW'(70);
      wait_done(ok);
      drive_to(70);

      issue_one(90);
      wait_busy();
      repeat (40) @(negedge clk);
      enable = 1'b0;
      wait_done(ok);
      i_ref_in = BW'(300);
      fs = frame_starts;
      repeat (300) @(negedge clk);
      check("disabled_no_frame", frame_starts - fs, 0);
      check("disabled_applied", int'(i_ref_applied), model);
      enable = 1'b1;
      drive_to(300);

      issue_one(500);
      wait_busy();
      repeat (30) @(negedge clk);
      lc = ldac_count;
      rst = 1'b1;
      @(negedge clk);
      check("abort_cs_n", int'(dac_cs_n), 1);
      check("abort_sclk", int'(dac_sclk), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_applied", int'(i_ref_applied), 0);
      check("abort_ldac_n", int'(dac_ldac_n), 1);
      check("abort_no_ldac", ldac_count - lc, 0);
      exp_q.delete();
      model = 0;
      i_ref_in = BW'(200);
      rst = 1'b0;
      drive_to(200);

      repeat (6) begin
         v = int'($urandom_range(0, (1 << BW) - 1));
         if (v == model) v = v ^ 1;
         drive_to(v);
      end

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
